// File: rtl/fetch_decode_queue_if.sv
// Fetch/decode handshake bundle for the fetch-to-decode instruction queue.
// master = the environment (fetch unit and decode control); slave = the queue.
interface fetch_decode_queue_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
);
  localparam int CW = $clog2(DEPTH + 1);

  // fetch side
  logic [XLEN-1:0] PC_f;
  logic [XLEN-1:0] inst_f;
  logic            valid_f;
  logic            ready_f;
  // decode side
  logic            stall;
  logic            kill_dx;
  logic [XLEN-1:0] PC_d;
  logic [XLEN-1:0] inst_d;
  logic            valid_d;
  logic [4:0]      addr_rs1;
  logic [4:0]      addr_rs2;
  logic [CW-1:0]   count;

  modport master (
    output PC_f, inst_f, valid_f, stall, kill_dx,
    input  ready_f, PC_d, inst_d, valid_d, addr_rs1, addr_rs2, count
  );

  modport slave (
    input  PC_f, inst_f, valid_f, stall, kill_dx,
    output ready_f, PC_d, inst_d, valid_d, addr_rs1, addr_rs2, count
  );
endinterface

// File: rtl/fetch_decode_queue.sv
// DEPTH-entry FIFO of {PC, instruction} between fetch and decode.
// Fetch pushes with valid/ready; decode sees the oldest entry or a NOP bubble,
// and controls consumption with stall and flushing with kill_dx.
module fetch_decode_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 2,
  parameter logic [XLEN-1:0] NOP_INST = 32'h00000013
) (
  input  logic                 clk,
  input  logic                 reset,
  fetch_decode_queue_if.slave  q
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [PW-1:0]              wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]              rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]              count_q, count_d;
  logic [DEPTH-1:0][XLEN-1:0] pc_mem_q, pc_mem_d;
  logic [DEPTH-1:0][XLEN-1:0] inst_mem_q, inst_mem_d;

  logic            empty, ready, push, pop;
  logic [XLEN-1:0] head_pc, head_inst;

  // Handshake qualifiers; ready depends only on registered count so stall/kill
  // never reach ready_f combinationally.
  always_comb begin
    empty = (count_q == '0);
    ready = (count_q != CW'(DEPTH));
    push  = q.valid_f & ready & ~q.kill_dx;
    pop   = ~empty & ~q.stall & ~q.kill_dx;
  end

  // Pointer and occupancy next state; kill flushes everything, incoming word included.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (q.kill_dx) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Storage write: only the slot at the write pointer changes, and only on a push.
  always_comb begin
    pc_mem_d   = pc_mem_q;
    inst_mem_d = inst_mem_q;
    if (push) begin
      pc_mem_d[wr_ptr_q]   = q.PC_f;
      inst_mem_d[wr_ptr_q] = q.inst_f;
    end
  end

  // Control state register; reset wins over kill, push and pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage register; contents are meaningless outside the occupied window so no reset.
  always_ff @(posedge clk) begin
    pc_mem_q   <= pc_mem_d;
    inst_mem_q <= inst_mem_d;
  end

  // Head read straight from storage; an empty queue presents a NOP bubble at PC 0.
  always_comb begin
    head_pc   = '0;
    head_inst = NOP_INST;
    if (!empty) begin
      head_pc   = pc_mem_q[rd_ptr_q];
      head_inst = inst_mem_q[rd_ptr_q];
    end
  end

  assign q.ready_f  = ready;
  assign q.PC_d     = head_pc;
  assign q.inst_d   = head_inst;
  assign q.valid_d  = ~empty;
  assign q.addr_rs1 = head_inst[19:15];
  assign q.addr_rs2 = head_inst[24:20];
  assign q.count    = count_q;
endmodule

// File: tb/tb_fetch_decode_queue.sv
// Bench for fetch_decode_queue: queue-based reference model, per-cycle compare,
// directed scenarios with literal expectations, and a randomized phase.
module tb_fetch_decode_queue;
  localparam int XLEN  = 32;
  localparam int DEPTH = 2;
  localparam logic [31:0] NOP = 32'h00000013;

  typedef struct { logic [31:0] pc; logic [31:0] inst; } entry_t;

  logic clk = 1'b0;
  logic reset;
  fetch_decode_queue_if #(.XLEN(XLEN), .DEPTH(DEPTH)) fq ();

  fetch_decode_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .NOP_INST(NOP)) dut (
    .clk   (clk),
    .reset (reset),
    .q     (fq.slave)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  bit started = 0;

  entry_t      mq[$];       // model queue, head at index 0
  logic [31:0] pop_log[$];  // PCs the model says decode consumed

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: FIFO semantics applied at each rising edge.
  always @(posedge clk) begin
    automatic bit do_push, do_pop;
    if (reset) begin
      mq.delete();
      started = 1;
    end else if (fq.kill_dx) begin
      mq.delete();
    end else begin
      do_push = fq.valid_f && (mq.size() < DEPTH);
      do_pop  = (mq.size() > 0) && !fq.stall;
      if (do_pop) begin
        pop_log.push_back(mq[0].pc);
        void'(mq.pop_front());
      end
      if (do_push) mq.push_back('{pc: fq.PC_f, inst: fq.inst_f});
    end
  end

  // Per-cycle comparison of every output against the model, away from the edge.
  always @(negedge clk) begin
    if (started) begin
      automatic logic [31:0] epc  = (mq.size() == 0) ? 32'h0 : mq[0].pc;
      automatic logic [31:0] eins = (mq.size() == 0) ? NOP   : mq[0].inst;
      chk("pc_d",    fq.PC_d,     epc);
      chk("inst_d",  fq.inst_d,   eins);
      chk("valid_d", fq.valid_d,  mq.size() != 0);
      chk("rs1",     fq.addr_rs1, eins[19:15]);
      chk("rs2",     fq.addr_rs2, eins[24:20]);
      chk("count",   fq.count,    mq.size());
      chk("ready_f", fq.ready_f,  mq.size() != DEPTH);
    end
  end

  task automatic drive(input bit rst, input bit v, input logic [31:0] pc,
                       input logic [31:0] ins, input bit st, input bit kl);
    reset      = rst;
    fq.valid_f = v;
    fq.PC_f    = pc;
    fq.inst_f  = ins;
    fq.stall   = st;
    fq.kill_dx = kl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] pc;
    int sent;
    int c;
    reset = 1'b1; fq.valid_f = 1'b0; fq.PC_f = '0; fq.inst_f = '0;
    fq.stall = 1'b0; fq.kill_dx = 1'b0;

    // 1. reset with valid_f high
    drive(1, 1, 32'h200, 32'h11111111, 0, 0);
    drive(1, 1, 32'h204, 32'h22222222, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    chk("rst_pc",    fq.PC_d, 32'h0);
    chk("rst_inst",  fq.inst_d, 32'h13);
    chk("rst_valid", fq.valid_d, 1'b0);
    chk("rst_count", fq.count, 2'd0);
    chk("rst_ready", fq.ready_f, 1'b1);

    // 2. fill under stall
    drive(0, 1, 32'h00, 32'h00500093, 1, 0);
    chk("fill1_count", fq.count, 2'd1);
    chk("fill1_pc",    fq.PC_d, 32'h0);
    drive(0, 1, 32'h04, 32'h00A00113, 1, 0);
    chk("fill2_count", fq.count, 2'd2);
    chk("fill2_ready", fq.ready_f, 1'b0);
    chk("fill2_rs1",   fq.addr_rs1, 5'd0);
    drive(0, 1, 32'h08, 32'h00F00193, 1, 0);
    chk("full_count",  fq.count, 2'd2);
    chk("full_pc",     fq.PC_d, 32'h0);

    // 3. drain with overlap
    pop_log.delete();
    drive(0, 1, 32'h08, 32'h00F00193, 0, 0);
    chk("drain_pc1",   fq.PC_d, 32'h04);
    chk("drain_cnt1",  fq.count, 2'd1);
    drive(0, 1, 32'h08, 32'h00F00193, 0, 0);
    chk("overlap_pc",  fq.PC_d, 32'h08);
    chk("overlap_cnt", fq.count, 2'd1);
    chk("overlap_rs2", fq.addr_rs2, 5'd15);
    drive(0, 0, 0, 0, 0, 0);
    chk("drain_cnt0",  fq.count, 2'd0);
    chk("drain_log_n", pop_log.size(), 3);
    if (pop_log.size() == 3) begin
      chk("drain_log0", pop_log[0], 32'h00);
      chk("drain_log1", pop_log[1], 32'h04);
      chk("drain_log2", pop_log[2], 32'h08);
    end

    // 4. wrap-around stream with stall toggling every third cycle
    pop_log.delete();
    pc = 32'h100; sent = 0; c = 0;
    while (sent < 10 && c < 200) begin
      automatic bit acc = (mq.size() < DEPTH);
      drive(0, 1, pc, 32'h00000013 | (pc << 13), ((c / 3) % 2) == 1, 0);
      if (acc) begin pc += 4; sent++; end
      c++;
    end
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 0, 0);
    chk("wrap_sent", sent, 10);
    chk("wrap_n", pop_log.size(), 10);
    for (int i = 0; i < pop_log.size() && i < 10; i++)
      chk("wrap_seq", pop_log[i], 32'h100 + 32'(4 * i));

    // 5. kill during stall with the queue full and valid_f high
    drive(0, 1, 32'h10, 32'h00100093, 1, 0);
    drive(0, 1, 32'h14, 32'h00200113, 1, 0);
    chk("k_full", fq.count, 2'd2);
    drive(0, 1, 32'h18, 32'h00300193, 1, 1);
    chk("k_count", fq.count, 2'd0);
    chk("k_valid", fq.valid_d, 1'b0);
    chk("k_inst",  fq.inst_d, 32'h13);
    chk("k_ready", fq.ready_f, 1'b1);
    drive(0, 1, 32'h40, 32'h00400213, 0, 0);
    chk("k_push_pc",    fq.PC_d, 32'h40);
    chk("k_push_valid", fq.valid_d, 1'b1);
    drive(0, 0, 0, 0, 0, 0);

    // 6. reset mid-operation together with kill
    drive(0, 1, 32'h50, 32'h00500293, 1, 0);
    drive(0, 1, 32'h54, 32'h00600313, 1, 0);
    drive(1, 1, 32'h58, 32'h00700393, 1, 1);
    chk("r6_count", fq.count, 2'd0);
    chk("r6_pc",    fq.PC_d, 32'h0);
    chk("r6_inst",  fq.inst_d, 32'h13);
    chk("r6_ready", fq.ready_f, 1'b1);
    drive(0, 1, 32'h80, 32'h00800413, 1, 0);
    chk("r6_push_cnt", fq.count, 2'd1);
    chk("r6_push_pc",  fq.PC_d, 32'h80);

    // randomized phase checked by the per-cycle compare
    pc = 32'h1000;
    for (int i = 0; i < 600; i++) begin
      automatic bit v  = ($urandom % 4) != 0;
      automatic bit st = ($urandom % 3) == 0;
      automatic bit kl = ($urandom % 16) == 0;
      automatic bit rs = ($urandom % 100) == 0;
      automatic bit acc = v && !kl && !rs && (mq.size() < DEPTH);
      drive(rs, v, pc, $urandom, st, kl);
      if (acc) pc += 4;
    end
    drive(0, 0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/fetch_decode_queue.md
Name: fetch_decode_queue

Overview:
Parametrised successor to the single IF/ID pipeline register. It holds a DEPTH-entry FIFO of {PC, instruction} pairs between fetch and decode, using a valid/ready handshake on the fetch side and stall/kill control on the decode side. Fetch can run ahead of a stalled decode by up to DEPTH instructions. Decode always sees either the oldest queued instruction or a NOP bubble.

Parameters:
XLEN, 32, width of PC and instruction words
DEPTH, 2, number of queue entries; power of two, at least 2
NOP_INST, 32'h00000013, bubble instruction (addi x0,x0,0) presented when the queue is empty

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
PC_f  input  XLEN  PC of the fetched instruction
inst_f  input  XLEN  fetched instruction
valid_f  input  1  PC_f/inst_f are valid this cycle
ready_f  output  1  queue accepts an entry this cycle
stall  input  1  decode cannot consume the head this cycle
kill_dx  input  1  flush; discard all queued and incoming instructions
PC_d  output  XLEN  PC of the head entry; 0 when empty
inst_d  output  XLEN  head instruction; NOP_INST when empty
valid_d  output  1  head entry is real, not a bubble
addr_rs1  output  5  inst_d[19:15]
addr_rs2  output  5  inst_d[24:20]
count  output  $clog2(DEPTH+1)  number of occupied entries

Behaviour:
- Reset, synchronous, clk edge with reset=1:
  - count=0, read/write pointers=0.
  - Outputs: PC_d=0, inst_d=NOP_INST, valid_d=0, ready_f=1.
  - Reset overrides kill, push and pop in the same cycle.
  - Storage contents are don't-care.
- Push and pop conditions:
  - push = valid_f & ready_f & !kill_dx.
  - pop = valid_d & !stall & !kill_dx.
- ready_f = (count != DEPTH).
  - Purely a function of registered state. There is no combinational path from stall or kill_dx to ready_f.
  - A push is never accepted when the queue is full, even in a cycle where a pop also occurs.
- Head outputs (PC_d, inst_d, valid_d, addr_rs*) are a combinational read of registered storage at the read pointer.
  - When count==0: PC_d=0, inst_d=NOP_INST, valid_d=0.
- Latency: an entry pushed at edge N is visible on the head outputs after edge N, when the queue was empty before the push. There is no same-cycle bypass from the fetch inputs to the decode outputs.
- Ordering is strict FIFO. Pointers are log2(DEPTH) bits and wrap naturally.
- Count update:
  - push only: count+1.
  - pop only: count-1.
  - push and pop together: count unchanged; write and read occur at different slots.
  - neither: unchanged.
- Stall:
  - Head entry and pointers hold; outputs are stable while stall=1.
  - Pushes continue until full, then ready_f=0.
- Kill (kill_dx=1):
  - At the next edge, count=0 and both pointers reset to 0.
  - The incoming fetch word is dropped, even if valid_f & ready_f.
  - Kill has priority over stall. This is a deliberate change from the old register, where stall blocked kill.
  - After a kill edge the outputs show the NOP bubble until a new push.
- Pointer overflow or underflow is impossible by construction. No push occurs at full and no pop occurs at empty.

Test Plan:
1. Reset: assert reset for 2 cycles with valid_f=1 -> PC_d=0, inst_d=32'h13, valid_d=0, count=0, ready_f=1.
2. Fill under stall: stall=1, push PC 0x00/0x04 with inst 0x00500093/0x00A00113 (DEPTH=2) -> count=2, ready_f=0, head PC_d=0x00, addr_rs1=0. A third offered word (PC 0x08) is not accepted.
3. Drain with overlap: release stall while valid_f offers 0x08 -> head sequence 0x00, 0x04, 0x08. Push and pop coincide once at count=1; count holds and no entry is lost.
4. Wrap-around: stream 10 sequential PCs with stall toggling every third cycle -> PC_d sequence is strictly increasing by 4, with no duplicates or skips across pointer wrap.
5. Kill during stall with the queue full and valid_f=1 -> next cycle count=0, valid_d=0, inst_d=32'h13, ready_f=1. The next push (PC 0x40) appears at the head one cycle later.
6. Reset mid-operation: assert reset with count=2 and kill_dx=1 -> all reset values are reached after one edge, and the queue accepts a push on the following cycle.
